// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive checker for the six-lamp two-head traffic-light
//               interface. Registers the lamp drives and the maintenance
//               flag, decodes the displayed phase, times each phase against
//               the normal / maintenance tables and latches the first
//               protocol violation.
// Ports       : clk, reset_n         - clock (CLK_HZ) and async active-low reset
//               maintain_i           - maintenance mode flag
//               red1_i..green2_i     - lamp drives for head 1 and head 2
//               clear_fault_i        - single-cycle fault clear
//               phase_o/phase_valid_o- decoded phase (7 = not a legal pattern)
//               phase_sec_o          - whole seconds in current phase (sat.)
//               fault_o/fault_code_o - latched first fault and its cause
//               cycle_done_o         - pulse per completed R1G2->R1Y2 cycle
//               cycle_count_o        - completed cycles (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int CLK_HZ     = 1024,
    parameter int TOL        = 1,
    parameter int NORM_R1Y2  = 250,
    parameter int NORM_G1R2  = 2500,
    parameter int NORM_Y1R2  = 250,
    parameter int NORM_R1G2  = 2250,
    parameter int MAINT_R1Y2 = 2,
    parameter int MAINT_G1R2 = 5,
    parameter int MAINT_Y1R2 = 2,
    parameter int MAINT_R1G2 = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        maintain_i,
    input  logic        red1_i,
    input  logic        yellow1_i,
    input  logic        green1_i,
    input  logic        red2_i,
    input  logic        yellow2_i,
    input  logic        green2_i,
    input  logic        clear_fault_i,
    output logic [2:0]  phase_o,
    output logic        phase_valid_o,
    output logic [11:0] phase_sec_o,
    output logic        fault_o,
    output logic [2:0]  fault_code_o,
    output logic        cycle_done_o,
    output logic [15:0] cycle_count_o
);

    typedef enum logic [2:0] {
        PH_Y1Y2    = 3'd0,
        PH_R1Y2    = 3'd1,
        PH_G1R2    = 3'd2,
        PH_Y1R2    = 3'd3,
        PH_R1G2    = 3'd4,
        PH_UNKNOWN = 3'd5,
        PH_NONE    = 3'd7
    } phase_e;

    // Lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
    localparam logic [5:0] LAMP_Y1Y2 = 6'b010_010;
    localparam logic [5:0] LAMP_R1Y2 = 6'b100_010;
    localparam logic [5:0] LAMP_G1R2 = 6'b001_100;
    localparam logic [5:0] LAMP_Y1R2 = 6'b010_100;
    localparam logic [5:0] LAMP_R1G2 = 6'b100_001;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_PATTERN    = 3'd1;
    localparam logic [2:0] FC_TRANSITION = 3'd2;
    localparam logic [2:0] FC_SHORT      = 3'd3;
    localparam logic [2:0] FC_LONG       = 3'd4;

    localparam int             SUB_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CLK_HZ - 1);

    // Expected length in seconds of a phase for the given mode.
    function automatic int exp_len(input phase_e p, input logic maint);
        int len;
        len = 0;
        case (p)
            PH_R1Y2: len = maint ? MAINT_R1Y2 : NORM_R1Y2;
            PH_G1R2: len = maint ? MAINT_G1R2 : NORM_G1R2;
            PH_Y1R2: len = maint ? MAINT_Y1R2 : NORM_Y1R2;
            PH_R1G2: len = maint ? MAINT_R1G2 : NORM_R1G2;
            default: len = 0;
        endcase
        return len;
    endfunction

    // Controller reset (->Y1Y2) and recovery from UNKNOWN are always legal.
    function automatic logic trans_ok(input phase_e from_p, input phase_e to_p);
        logic ok;
        ok = 1'b0;
        if (from_p == PH_UNKNOWN || to_p == PH_Y1Y2) begin
            ok = 1'b1;
        end else begin
            case (from_p)
                PH_Y1Y2: ok = (to_p == PH_R1Y2);
                PH_R1Y2: ok = (to_p == PH_G1R2);
                PH_G1R2: ok = (to_p == PH_Y1R2);
                PH_Y1R2: ok = (to_p == PH_R1G2);
                PH_R1G2: ok = (to_p == PH_R1Y2);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Registered state
    logic [5:0]       lamps_q;
    logic             maint_q;
    phase_e           phase_q;
    phase_e           prev_q;     // last legal phase, UNKNOWN after an illegal pattern
    logic             valid_q;
    logic [SUB_W-1:0] sub_q;
    logic [11:0]      sec_q;
    logic             mode_q;     // maintain value captured at phase entry
    logic             skip_q;     // duration checks disabled for this phase
    logic             fault_q;
    logic [2:0]       code_q;
    logic             done_q;
    logic [15:0]      count_q;

    // Next-state / combinational terms
    phase_e     phase_d;
    logic       valid_d;
    logic       skip_entry_d;
    logic       cycle_d;
    logic [2:0] code_d;
    logic       w_change;
    logic       w_tick;
    logic       w_skip;
    logic       w_checked;
    int         w_exp;
    logic       w_pat_err;
    logic       w_trans_err;
    logic       w_short;
    logic       w_long;

    always_comb begin
        phase_d = PH_NONE;
        case (lamps_q)
            LAMP_Y1Y2: phase_d = PH_Y1Y2;
            LAMP_R1Y2: phase_d = PH_R1Y2;
            LAMP_G1R2: phase_d = PH_G1R2;
            LAMP_Y1R2: phase_d = PH_Y1R2;
            LAMP_R1G2: phase_d = PH_R1G2;
            default:   phase_d = PH_NONE;
        endcase

        valid_d  = (phase_d != PH_NONE);
        w_change = (phase_d != phase_q);
        w_tick   = (sub_q == SUB_MAX);

        // A mode flip anywhere inside the phase disables its checks at once.
        w_skip    = skip_q || (maint_q != mode_q);
        w_checked = ((phase_q == PH_R1Y2) || (phase_q == PH_G1R2) ||
                     (phase_q == PH_Y1R2) || (phase_q == PH_R1G2)) && !w_skip;
        w_exp     = exp_len(phase_q, mode_q);

        // Raised on entry to an illegal pattern; a dark interface straight
        // out of reset is not a violation.
        w_pat_err   = !valid_d && (phase_q != PH_NONE);
        w_trans_err = w_change && valid_d && !trans_ok(prev_q, phase_d);
        w_short     = w_change && w_checked && (int'(sec_q) < (w_exp - TOL));
        // Flag on the edge where phase_sec becomes E+TOL+1.
        w_long      = !w_change && w_checked && w_tick &&
                      (int'(sec_q) == (w_exp + TOL));

        code_d = FC_NONE;
        if (w_pat_err) begin
            code_d = FC_PATTERN;
        end else if (w_trans_err) begin
            code_d = FC_TRANSITION;
        end else if (w_short) begin
            code_d = FC_SHORT;
        end else if (w_long) begin
            code_d = FC_LONG;
        end

        // First phase after UNKNOWN or Y1Y2 is partial; Y1Y2 itself is untimed.
        skip_entry_d = (phase_d == PH_Y1Y2) || (prev_q == PH_UNKNOWN) ||
                       (prev_q == PH_Y1Y2) || !valid_d;
        cycle_d      = w_change && (prev_q == PH_R1G2) && (phase_d == PH_R1Y2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamps_q <= '0;
            maint_q <= 1'b0;
            phase_q <= PH_NONE;
            prev_q  <= PH_UNKNOWN;
            valid_q <= 1'b0;
            sub_q   <= '0;
            sec_q   <= '0;
            mode_q  <= 1'b0;
            skip_q  <= 1'b1;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            lamps_q <= {red1_i, yellow1_i, green1_i, red2_i, yellow2_i, green2_i};
            maint_q <= maintain_i;
            valid_q <= valid_d;
            done_q  <= cycle_d;

            if (cycle_d && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end

            if (w_change) begin
                phase_q <= phase_d;
                prev_q  <= valid_d ? phase_d : PH_UNKNOWN;
                sub_q   <= '0;
                sec_q   <= '0;
                mode_q  <= maint_q;
                skip_q  <= skip_entry_d;
            end else begin
                if (w_tick) begin
                    sub_q <= '0;
                    if (sec_q != 12'hFFF) begin
                        sec_q <= sec_q + 12'd1;
                    end
                end else begin
                    sub_q <= sub_q + SUB_W'(1);
                end
                if (maint_q != mode_q) begin
                    skip_q <= 1'b1;
                end
            end

            // A new fault wins over a simultaneous clear.
            if ((code_d != FC_NONE) && (!fault_q || clear_fault_i)) begin
                fault_q <= 1'b1;
                code_q  <= code_d;
            end else if (clear_fault_i) begin
                fault_q <= 1'b0;
                code_q  <= FC_NONE;
            end
        end
    end

    assign phase_o       = phase_q;
    assign phase_valid_o = valid_q;
    assign phase_sec_o   = sec_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = code_q;
    assign cycle_done_o  = done_q;
    assign cycle_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed self-checking bench for traffic_light_monitor with
//               CLK_HZ=4. Expected phase/fault state is queued when a lamp
//               pattern is driven and compared two edges later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam int HZ = 4;

    localparam logic [5:0] P_DARK = 6'b000_000;
    localparam logic [5:0] P_Y1Y2 = 6'b010_010;
    localparam logic [5:0] P_R1Y2 = 6'b100_010;
    localparam logic [5:0] P_G1R2 = 6'b001_100;
    localparam logic [5:0] P_Y1R2 = 6'b010_100;
    localparam logic [5:0] P_R1G2 = 6'b100_001;
    localparam logic [5:0] P_GG   = 6'b001_001;

    logic        clk;
    logic        reset_n;
    logic        maintain;
    logic        red1, yellow1, green1, red2, yellow2, green2;
    logic        clear_fault;
    logic [2:0]  phase;
    logic        phase_valid;
    logic [11:0] phase_sec;
    logic        fault;
    logic [2:0]  fault_code;
    logic        cycle_done;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] ph;
        logic       vld;
        logic       flt;
        logic [2:0] code;
    } exp_t;

    exp_t sb[$];

    traffic_light_monitor #(.CLK_HZ(HZ)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .maintain_i    (maintain),
        .red1_i        (red1),
        .yellow1_i     (yellow1),
        .green1_i      (green1),
        .red2_i        (red2),
        .yellow2_i     (yellow2),
        .green2_i      (green2),
        .clear_fault_i (clear_fault),
        .phase_o       (phase),
        .phase_valid_o (phase_valid),
        .phase_sec_o   (phase_sec),
        .fault_o       (fault),
        .fault_code_o  (fault_code),
        .cycle_done_o  (cycle_done),
        .cycle_count_o (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] p);
        {red1, yellow1, green1, red2, yellow2, green2} = p;
    endtask

    task automatic push_exp(input string tag, input logic [2:0] ph, input logic vld,
                            input logic flt, input logic [2:0] code);
        exp_t e;
        e.tag  = tag;
        e.ph   = ph;
        e.vld  = vld;
        e.flt  = flt;
        e.code = code;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".phase"}, 32'(phase), 32'(e.ph));
            chk({e.tag, ".valid"}, 32'(phase_valid), 32'(e.vld));
            chk({e.tag, ".fault"}, 32'(fault), 32'(e.flt));
            chk({e.tag, ".code"}, 32'(fault_code), 32'(e.code));
        end
    endtask

    // Drive a pattern, queue its expectation and compare once it is visible
    // (input register plus decode register = two edges).
    task automatic step(input string tag, input logic [5:0] p, input logic [2:0] ph,
                        input logic vld, input logic flt, input logic [2:0] code);
        drive(p);
        push_exp(tag, ph, vld, flt, code);
        tick(2);
        check_sb();
    endtask

    // Fault-free phase shown for exactly n clock edges.
    task automatic seg(input string tag, input logic [5:0] p, input logic [2:0] ph,
                       input int n);
        step(tag, p, ph, 1'b1, 1'b0, 3'd0);
        tick(n - 2);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'd7);
        chk({tag, ".valid"}, 32'(phase_valid), 32'd0);
        chk({tag, ".sec"}, 32'(phase_sec), 32'd0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".code"}, 32'(fault_code), 32'd0);
        chk({tag, ".done"}, 32'(cycle_done), 32'd0);
        chk({tag, ".count"}, 32'(cycle_count), 32'd0);
    endtask

    task automatic apply_reset(input logic m);
        reset_n     = 1'b0;
        maintain    = m;
        clear_fault = 1'b0;
        drive(P_DARK);
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        reset_n     = 1'b1;
        maintain    = 1'b1;
        clear_fault = 1'b0;
        drive(P_DARK);
        #1;

        // ---- reset values ----
        reset_n = 1'b0;
        tick(2);
        check_reset_values("rst");
        reset_n = 1'b1;
        tick(3);
        chk("dark_after_reset.fault", 32'(fault), 32'd0);

        // ---- normal maintenance cycle ----
        seg("cyc_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("cyc_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        seg("cyc_g1r2", P_G1R2, 3'd2, 5 * HZ);
        chk("cyc_g1r2.sec_before_exit", 32'(phase_sec), 32'd4);
        seg("cyc_y1r2", P_Y1R2, 3'd3, 2 * HZ);
        seg("cyc_r1g2", P_R1G2, 3'd4, 5 * HZ);
        step("cyc_r1y2_wrap", P_R1Y2, 3'd1, 1'b1, 1'b0, 3'd0);
        chk("cyc.done_pulse", 32'(cycle_done), 32'd1);
        chk("cyc.count", 32'(cycle_count), 32'd1);
        tick(1);
        chk("cyc.done_low", 32'(cycle_done), 32'd0);
        chk("cyc.count_hold", 32'(cycle_count), 32'd1);
        tick(2 * HZ - 3);

        // ---- asynchronous reset in the middle of R1G2 ----
        seg("cyc2_g1r2", P_G1R2, 3'd2, 5 * HZ);
        seg("cyc2_y1r2", P_Y1R2, 3'd3, 2 * HZ);
        step("cyc2_r1g2", P_R1G2, 3'd4, 1'b1, 1'b0, 3'd0);
        tick(5);
        chk("mid_r1g2.sec", 32'(phase_sec), 32'd1);
        reset_n = 1'b0;
        #2;
        check_reset_values("async_rst");
        tick(1);
        reset_n = 1'b1;
        drive(P_DARK);
        tick(2);

        // ---- both greens, then recovery keeps code 1 ----
        apply_reset(1'b1);
        seg("gg_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        step("gg_r1y2", P_R1Y2, 3'd1, 1'b1, 1'b0, 3'd0);
        step("gg_both_green", P_GG, 3'd7, 1'b0, 1'b1, 3'd1);
        step("gg_recover", P_R1Y2, 3'd1, 1'b1, 1'b1, 3'd1);

        // ---- illegal transition G1R2->R1G2, then clear ----
        apply_reset(1'b1);
        seg("it_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("it_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        seg("it_g1r2", P_G1R2, 3'd2, 5 * HZ);
        step("it_skip_y1r2", P_R1G2, 3'd4, 1'b1, 1'b1, 3'd2);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("it_clear.fault", 32'(fault), 32'd0);
        chk("it_clear.code", 32'(fault_code), 32'd0);

        // ---- short Y1R2 after a checked G1R2 ----
        apply_reset(1'b1);
        seg("sh_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("sh_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        seg("sh_g1r2", P_G1R2, 3'd2, 5 * HZ);
        step("sh_y1r2", P_Y1R2, 3'd3, 1'b1, 1'b0, 3'd0);
        step("sh_exit", P_R1G2, 3'd4, 1'b1, 1'b1, 3'd3);

        // ---- long G1R2 (maintenance), then clear/pattern collision ----
        apply_reset(1'b1);
        seg("lg_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("lg_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        step("lg_g1r2", P_G1R2, 3'd2, 1'b1, 1'b0, 3'd0);
        tick(7 * HZ - 1);
        chk("lg_6s.sec", 32'(phase_sec), 32'd6);
        chk("lg_6s.fault", 32'(fault), 32'd0);
        tick(1);
        chk("lg_7s.sec", 32'(phase_sec), 32'd7);
        chk("lg_7s.phase", 32'(phase), 32'd2);
        chk("lg_7s.fault", 32'(fault), 32'd1);
        chk("lg_7s.code", 32'(fault_code), 32'd4);
        drive(P_DARK);
        tick(1);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("collide.phase", 32'(phase), 32'd7);
        chk("collide.fault", 32'(fault), 32'd1);
        chk("collide.code", 32'(fault_code), 32'd1);

        // ---- maintain toggled inside G1R2, exit at 9 s ----
        apply_reset(1'b1);
        seg("mt_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("mt_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        step("mt_g1r2", P_G1R2, 3'd2, 1'b1, 1'b0, 3'd0);
        maintain = 1'b0;
        tick(4);
        maintain = 1'b1;
        tick(9 * HZ - 6);
        chk("mt_before_exit.sec", 32'(phase_sec), 32'd8);
        step("mt_exit", P_Y1R2, 3'd3, 1'b1, 1'b0, 3'd0);

        // ---- normal mode G1R2: 2500 s passes ----
        apply_reset(1'b0);
        seg("nm_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("nm_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        seg("nm_g1r2", P_G1R2, 3'd2, 2500 * HZ);
        chk("nm_2500.sec", 32'(phase_sec), 32'd2499);
        step("nm_exit", P_Y1R2, 3'd3, 1'b1, 1'b0, 3'd0);

        // ---- normal mode G1R2: 2502 s is long ----
        apply_reset(1'b0);
        seg("nl_y1y2", P_Y1Y2, 3'd0, 1 * HZ);
        seg("nl_r1y2", P_R1Y2, 3'd1, 2 * HZ);
        step("nl_g1r2", P_G1R2, 3'd2, 1'b1, 1'b0, 3'd0);
        tick(2502 * HZ - 1);
        chk("nl_2501.sec", 32'(phase_sec), 32'd2501);
        chk("nl_2501.fault", 32'(fault), 32'd0);
        tick(1);
        chk("nl_2502.sec", 32'(phase_sec), 32'd2502);
        chk("nl_2502.fault", 32'(fault), 32'd1);
        chk("nl_2502.code", 32'(fault_code), 32'd4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the far end of the six-lamp traffic-light interface.
- Samples red/yellow/green for both heads, decodes the displayed phase, times each phase against the normal and maintenance timing tables, and latches the first protocol violation.
- Sits beside the intersection controller; feeds the status/fault logic and the bench scoreboard.

Parameters:
- CLK_HZ, 1024: clock cycles per second.
- TOL, 1: allowed phase-length error, whole seconds.
- NORM_R1Y2 250, NORM_G1R2 2500, NORM_Y1R2 250, NORM_R1G2 2250: normal phase lengths, seconds.
- MAINT_R1Y2 2, MAINT_G1R2 5, MAINT_Y1R2 2, MAINT_R1G2 5: maintenance phase lengths, seconds.

Ports:
- clk  in  1  system clock, CLK_HZ.
- reset_n  in  1  reset.
- maintain  in  1  maintenance mode, same signal the controller uses.
- red1, yellow1, green1, red2, yellow2, green2  in  1 each  lamp drives.
- clear_fault  in  1  single-cycle fault clear.
- phase  out  3  decoded phase.
- phase_valid  out  1  current pattern is legal.
- phase_sec  out  12  whole seconds elapsed in current phase, saturating at 4095.
- fault  out  1  fault latched.
- fault_code  out  3  first fault cause.
- cycle_done  out  1  one-cycle pulse per completed full cycle.
- cycle_count  out  16  completed cycles, saturating at 65535.

Interface: one clock; reset is asynchronous and active-low. Ports are named clk and reset_n.

Behaviour:
- **Reset values:** phase=7, phase_valid=0, phase_sec=0, fault=0, fault_code=0, cycle_done=0, cycle_count=0. The previous-phase tracker is UNKNOWN (5). The input registers hold 0.
- **Input stage:** lamps and maintain registered once. Decode and checks run on the registered copy.
- **Latency:** a lamp change present before edge k is reflected on phase, phase_valid and any fault at edge k+1.
- **Decode (exact 6-bit match):**
  - Y1Y2 = 0 (Y,Y)
  - R1Y2 = 1
  - G1R2 = 2
  - Y1R2 = 3
  - R1G2 = 4
  - Any other pattern (dark, both green, two lamps on one head, …) gives phase=7, phase_valid=0.
- **Phase timer:**
  - Sub-counter counts 0..CLK_HZ-1; at wrap phase_sec increments.
  - On every phase change, both the sub-counter and phase_sec clear to 0 on the same edge that updates phase.
- **Mode latch:** maintain is captured at phase entry. If the registered maintain differs from the captured value at any point in the phase, set skip and do no duration checks for that phase.
- **Legal transitions:**
  - Y1Y2→R1Y2, R1Y2→G1R2, G1R2→Y1R2, Y1R2→R1G2, R1G2→R1Y2.
  - Any legal phase→Y1Y2 (controller reset) is legal.
  - UNKNOWN→any legal phase is legal.
  - Entry from UNKNOWN or Y1Y2 skips the duration check of the first phase (partial phase).
  - Y1Y2 is never duration-checked.
- **Duration check:** expected E is from the table, selected by the captured mode.
  - On exit, phase_sec < E-TOL → SHORT.
  - While in phase, phase_sec reaching E+TOL+1 → LONG, flagged immediately without waiting for exit.
- **Fault codes:** 1 ILLEGAL_PATTERN, 2 ILLEGAL_TRANSITION, 3 SHORT_PHASE, 4 LONG_PHASE.
  - Priority within one cycle: 1 > 2 > 3 > 4.
- **Latching:**
  - The first fault sets fault=1 and fault_code; they hold until clear_fault.
  - Later faults are ignored while latched.
  - If clear_fault and a new fault occur in the same cycle, the new fault is latched.
- **Illegal pattern handling:** the previous-phase tracker becomes UNKNOWN. Recovery to any legal phase raises no transition fault.
- **Cycle counting:** an R1G2→R1Y2 transition pulses cycle_done for one cycle and increments cycle_count (saturating).
- **Reset mid-phase:** all state returns to reset values immediately; no fault is raised by the interruption.

Test Plan:
- **Normal maintenance cycle:** CLK_HZ=4, maintain=1; drive Y1Y2 for 1 s, then R1Y2 2 s, G1R2 5 s, Y1R2 2 s, R1G2 5 s, R1Y2 → fault stays 0; phase sequence 0,1,2,3,4,1; cycle_done pulses once; cycle_count=1; phase_sec reads 4 just before G1R2 exit.
- **Both greens:** drive green1=green2=1, reds 0 → two edges later phase=7, phase_valid=0, fault=1, fault_code=1. A subsequent legal R1Y2 leaves the code at 1.
- **Illegal transition:** G1R2 directly to R1G2 after a full checked G1R2 → fault_code=2. Assert clear_fault → fault=0 next edge.
- **Short and long phases:** maintain=1.
  - Hold Y1R2 for only 0 whole seconds after a checked G1R2 → fault_code=3.
  - Separately, hold G1R2 for 7 s → fault_code=4 when phase_sec reaches 7 (E+TOL+1), while still in G1R2.
- **Mode change mid-phase:** toggle maintain during G1R2 and exit at 9 s → no fault. With CLK_HZ=4, hold G1R2 in normal mode 2500 s → no fault; 2502 s → fault_code=4.
- **Collision and reset:**
  - clear_fault asserted in the same cycle as an illegal pattern → fault=1, fault_code=1.
  - Drop reset_n mid-R1G2 → all outputs at reset values asynchronously, before the next clk edge.
